// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice.
// Holds the ALU operation codes, the legality check used to bypass the ALU
// for unsupported codes, and the arbiter FSM state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    function automatic logic is_legal_op(input logic [3:0] op);
        logic legal;
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: legal = 1'b1;
            default:                                     legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_main.sv
// Combinational ALU shared by the arbiter.
// Ports:
//   operation          : 4-bit operation code
//   operand1/operand2  : WIDTH-bit operands
//   result             : WIDTH-bit result
//   zero               : result == 0
module alu_main import alu_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    logic w_lt;

    assign w_lt = $signed(operand1) < $signed(operand2);

    always_comb begin
        result = '0;
        case (operation)
            ALU_AND: result = operand1 & operand2;
            ALU_OR:  result = operand1 | operand2;
            ALU_ADD: result = operand1 + operand2;
            ALU_SUB: result = operand1 - operand2;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, w_lt};
            // Unsupported codes give all-ones so a stray capture would be visible.
            default: result = '1;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational.
// Ports:
//   i_valid0/i_valid1 : requests from requester 0/1
//   i_ptr             : requester favoured when both request (0 or 1)
//   o_gnt0/o_gnt1     : one-hot grant (or none when nobody requests)
module rr_arb2 (
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_ptr,
    output logic o_gnt0,
    output logic o_gnt1
);

    // A lone requester always wins; a tie goes to the pointer's side.
    assign o_gnt0 = i_valid0 & (~i_valid1 | ~i_ptr);
    assign o_gnt1 = i_valid1 & (~i_valid0 |  i_ptr);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin
// arbitration and valid/ready handshakes on request and response sides.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   reqN_valid/ready/op/a/b          : request channel of requester N
//   rspN_valid/ready/result/zero/err : response channel of requester N
//   alu_operation/operand1/operand2  : registered drive to the ALU
//   alu_result, alu_z                : ALU outputs, captured in EXEC
module alu_arbiter import alu_pkg::*; #(
    parameter int WIDTH      = 32,
    parameter int FAIR_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,
    output logic             rsp0_err,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,
    output logic             rsp1_err,
    output logic [3:0]       alu_operation,
    output logic [WIDTH-1:0] alu_operand1,
    output logic [WIDTH-1:0] alu_operand2,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_z
);

    localparam logic PTR_RESET = (FAIR_FIRST != 0);

    logic [1:0]       r_state;
    logic             r_owner;
    logic             r_ptr;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result0;
    logic [WIDTH-1:0] r_result1;
    logic             r_zero0;
    logic             r_zero1;
    logic             r_err0;
    logic             r_err1;

    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_idle;
    logic             w_req_hs;
    logic [3:0]       w_sel_op;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic             w_rsp_hs;

    rr_arb2 u_arb (
        .i_valid0 (req0_valid),
        .i_valid1 (req1_valid),
        .i_ptr    (r_ptr),
        .o_gnt0   (w_gnt0),
        .o_gnt1   (w_gnt1)
    );

    assign w_idle     = (r_state == IDLE);
    assign req0_ready = w_idle & w_gnt0;
    assign req1_ready = w_idle & w_gnt1;
    // A grant implies the winner is valid, so ready alone marks the handshake.
    assign w_req_hs   = req0_ready | req1_ready;

    assign w_sel_op = w_gnt1 ? req1_op : req0_op;
    assign w_sel_a  = w_gnt1 ? req1_a  : req0_a;
    assign w_sel_b  = w_gnt1 ? req1_b  : req0_b;

    assign rsp0_valid = (r_state == RESP) & ~r_owner;
    assign rsp1_valid = (r_state == RESP) &  r_owner;
    // Only the owner's ready can complete the response.
    assign w_rsp_hs   = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);

    assign rsp0_result = r_result0;
    assign rsp0_zero   = r_zero0;
    assign rsp0_err    = r_err0;
    assign rsp1_result = r_result1;
    assign rsp1_zero   = r_zero1;
    assign rsp1_err    = r_err1;

    assign alu_operation = r_op;
    assign alu_operand1  = r_a;
    assign alu_operand2  = r_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_owner   <= 1'b0;
            r_ptr     <= PTR_RESET;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_result0 <= '0;
            r_result1 <= '0;
            r_zero0   <= 1'b0;
            r_zero1   <= 1'b0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_hs) begin
                        r_op    <= w_sel_op;
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_owner <= w_gnt1;
                        if (is_legal_op(w_sel_op)) begin
                            r_state <= EXEC;
                        end else begin
                            // Illegal code: answer directly, ALU output unused.
                            if (w_gnt1) begin
                                r_result1 <= '0;
                                r_zero1   <= 1'b0;
                                r_err1    <= 1'b1;
                            end else begin
                                r_result0 <= '0;
                                r_zero0   <= 1'b0;
                                r_err0    <= 1'b1;
                            end
                            r_state <= RESP;
                        end
                    end
                end
                EXEC: begin
                    if (r_owner) begin
                        r_result1 <= alu_result;
                        r_zero1   <= alu_z;
                        r_err1    <= 1'b0;
                    end else begin
                        r_result0 <= alu_result;
                        r_zero0   <= alu_z;
                        r_err0    <= 1'b0;
                    end
                    r_state <= RESP;
                end
                RESP: begin
                    if (w_rsp_hs) begin
                        // Hand the tie-break to the other requester.
                        r_ptr   <= ~r_owner;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    typedef struct {
        logic        req;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        err;
        int          exp_first;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op = '0, req1_op = '0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [31:0] rsp0_result, rsp1_result;
    logic        rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
    logic [3:0]  alu_operation;
    logic [31:0] alu_operand1, alu_operand2, alu_result;
    logic        alu_z;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int blk0 = 0, blk1 = 0;
    bit hs0 = 0, hs1 = 0;
    logic ptr_m = 1'b0;
    item_t q0[$];
    item_t q1[$];
    item_t sb[$];
    logic glog[$];
    logic [1:0]  pv = '0;
    logic [31:0] pres[2];
    logic        pz[2];
    logic        pe[2];
    item_t vecs[10];

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32), .FAIR_FIRST(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
        .alu_operation(alu_operation), .alu_operand1(alu_operand1),
        .alu_operand2(alu_operand2), .alu_result(alu_result), .alu_z(alu_z)
    );

    alu_main #(.WIDTH(32)) u_alu (
        .operation(alu_operation), .operand1(alu_operand1), .operand2(alu_operand2),
        .result(alu_result), .zero(alu_z)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    function automatic item_t mk(input logic req, input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] res, input logic z,
                                 input logic err);
        item_t it;
        it.req = req; it.op = op; it.a = a; it.b = b;
        it.res = res; it.z = z; it.err = err; it.exp_first = 0;
        return it;
    endfunction

    task automatic push_req(input item_t it);
        if (it.req) q1.push_back(it);
        else        q0.push_back(it);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'({req1_ready, req0_ready}), 32'd0);
        chk({tag, "_rsp_valid"}, 32'({rsp1_valid, rsp0_valid}), 32'd0);
        chk({tag, "_rsp0_result"}, rsp0_result, 32'd0);
        chk({tag, "_rsp1_result"}, rsp1_result, 32'd0);
        chk({tag, "_zero_err"}, 32'({rsp1_zero, rsp0_zero, rsp1_err, rsp0_err}), 32'd0);
        chk({tag, "_alu_op"}, 32'(alu_operation), 32'd0);
        chk({tag, "_alu_a"}, alu_operand1, 32'd0);
        chk({tag, "_alu_b"}, alu_operand2, 32'd0);
    endtask

    // Sample the DUT at the falling edge: request side first, then response side.
    task automatic sample();
        logic [1:0]  exp_rdy;
        logic [1:0]  exp_v;
        logic [1:0]  vnow;
        logic [1:0]  rnow;
        logic [31:0] res_now[2];
        logic        z_now[2];
        logic        e_now[2];
        item_t       it;
        int          own;

        exp_rdy = 2'b00;
        if (sb.size() == 0) begin
            if (req0_valid && req1_valid) exp_rdy = ptr_m ? 2'b10 : 2'b01;
            else                          exp_rdy = {req1_valid, req0_valid};
        end
        chk("req_ready", 32'({req1_ready, req0_ready}), 32'(exp_rdy));

        if (req0_valid && req0_ready && q0.size() > 0) begin
            it = q0[0];
            it.exp_first = cyc + (it.err ? 1 : 2);
            sb.push_back(it);
            glog.push_back(1'b0);
            hs0 = 1;
        end
        if (req1_valid && req1_ready && q1.size() > 0) begin
            it = q1[0];
            it.exp_first = cyc + (it.err ? 1 : 2);
            sb.push_back(it);
            glog.push_back(1'b1);
            hs1 = 1;
        end

        exp_v = 2'b00;
        if (sb.size() > 0 && cyc >= sb[0].exp_first) exp_v = sb[0].req ? 2'b10 : 2'b01;
        vnow = {rsp1_valid, rsp0_valid};
        rnow = {rsp1_ready, rsp0_ready};
        chk("rsp_valid", 32'(vnow), 32'(exp_v));

        res_now[0] = rsp0_result; z_now[0] = rsp0_zero; e_now[0] = rsp0_err;
        res_now[1] = rsp1_result; z_now[1] = rsp1_zero; e_now[1] = rsp1_err;
        for (int i = 0; i < 2; i++) begin
            if (vnow[i]) begin
                if (pv[i]) begin
                    chk("hold_result", res_now[i], pres[i]);
                    chk("hold_flags", 32'({z_now[i], e_now[i]}), 32'({pz[i], pe[i]}));
                end
                pv[i] = 1'b1;
                pres[i] = res_now[i]; pz[i] = z_now[i]; pe[i] = e_now[i];
            end else begin
                pv[i] = 1'b0;
            end
        end

        if (exp_v != 2'b00) begin
            own = int'(sb[0].req);
            if (vnow[own] && rnow[own]) begin
                it = sb.pop_front();
                chk("rsp_result", res_now[own], it.res);
                chk("rsp_zero_err", 32'({z_now[own], e_now[own]}), 32'({it.z, it.err}));
                chk("alu_drive", 32'(alu_operation), 32'(it.op));
                chk("alu_operands", alu_operand1 ^ alu_operand2, it.a ^ it.b);
                $display("txn req%0d op=%b a=%h b=%h result=%h zero=%b err=%b",
                         own, it.op, it.a, it.b, res_now[own], z_now[own], e_now[own]);
                ptr_m = ~it.req;
                pv[own] = 1'b0;
            end
        end

        if (rsp0_valid && blk0 > 0) blk0--;
        if (rsp1_valid && blk1 > 0) blk1--;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        if (hs0 && q0.size() > 0) void'(q0.pop_front());
        if (hs1 && q1.size() > 0) void'(q1.pop_front());
        hs0 = 0; hs1 = 0;
        req0_valid = (q0.size() > 0);
        if (q0.size() > 0) begin req0_op = q0[0].op; req0_a = q0[0].a; req0_b = q0[0].b; end
        req1_valid = (q1.size() > 0);
        if (q1.size() > 0) begin req1_op = q1[0].op; req1_a = q1[0].a; req1_b = q1[0].b; end
        rsp0_ready = (blk0 == 0);
        rsp1_ready = (blk1 == 0);
        @(negedge clk);
        sample();
    endtask

    task automatic run_until_idle(input int budget, input string tag);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        if (q0.size() > 0 || q1.size() > 0 || sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout after %0d cycles pending=%0d", tag, n, sb.size());
            q0.delete(); q1.delete(); sb.delete();
        end
    endtask

    initial begin
        logic exp_order[6];

        vecs[0] = mk(1'b0, 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
        vecs[1] = mk(1'b1, 4'b0110, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0);
        vecs[2] = mk(1'b0, 4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0);
        vecs[3] = mk(1'b1, 4'b0001, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        vecs[4] = mk(1'b0, 4'b0111, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0);
        vecs[5] = mk(1'b1, 4'b0111, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0);
        vecs[6] = mk(1'b0, 4'b0010, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0);
        vecs[7] = mk(1'b1, 4'b0110, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0, 1'b0);
        vecs[8] = mk(1'b0, 4'b1111, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1);
        vecs[9] = mk(1'b1, 4'b0011, 32'd2, 32'd3, 32'd0, 1'b0, 1'b1);

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 1'b0;

        // Contention: both requesters keep valid asserted for six operations
        for (int i = 0; i < 3; i++) begin
            push_req(mk(1'b0, 4'b0010, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0));
            push_req(mk(1'b1, 4'b0001, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0));
        end
        glog.delete();
        run_until_idle(80, "contention");
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        chk("contention_grants", 32'(glog.size()), 32'd6);
        for (int i = 0; i < 6 && i < glog.size(); i++)
            chk("contention_order", 32'(glog[i]), 32'(exp_order[i]));

        // Table of single-requester operations
        for (int i = 0; i < 10; i++) begin
            push_req(vecs[i]);
            run_until_idle(20, "vector");
        end

        // Backpressure on requester 0 while requester 1 waits
        glog.delete();
        blk0 = 5;
        push_req(mk(1'b0, 4'b0010, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0));
        push_req(mk(1'b1, 4'b0000, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0, 1'b0));
        run_until_idle(40, "backpressure");
        chk("bp_grants", 32'(glog.size()), 32'd2);
        if (glog.size() == 2) chk("bp_order", 32'({glog[0], glog[1]}), 32'b01);

        // Leave the pointer at requester 1, then reset during EXEC
        push_req(mk(1'b0, 4'b0001, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0));
        run_until_idle(20, "pre_reset");
        push_req(mk(1'b0, 4'b0010, 32'h11, 32'h22, 32'h33, 1'b0, 1'b0));
        for (int n = 0; n < 10 && !hs0; n++) tick();
        chk("reset_setup_hs", 32'(hs0), 32'd1);
        @(posedge clk);
        cyc++;
        #2;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midop");
        q0.delete(); q1.delete(); sb.delete();
        hs0 = 0; hs1 = 0; pv = '0;
        ptr_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) tick();
        glog.delete();
        push_req(mk(1'b1, 4'b0010, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0));
        push_req(mk(1'b0, 4'b0110, 32'd20, 32'd10, 32'd10, 1'b0, 1'b0));
        run_until_idle(40, "post_reset");
        if (glog.size() > 0) chk("post_reset_first_grant", 32'(glog[0]), 32'd0);
        else chk("post_reset_grants", 32'(glog.size()), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
